conv3x3_window_ctrl: RTL
========================

Name: conv3x3_window_ctrl

Overview:
Sequencer that feeds the 3x3 fixed-point convolution datapath. It holds the nine 8-bit kernel weights and accepts a raster pixel stream over a valid/ready handshake. Two internal line buffers turn that stream into 3x3 windows, driven onto data_line0..2 with a one-cycle window-valid strobe. It counts the datapath's result strobes and signals end of frame.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- CNT_W, 16, width of result counter (must hold (IMG_W-2)*(IMG_H-2))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a frame when IDLE
- cfg_we  in  1  weight write strobe
- cfg_addr  in  4  weight index 0..8
- cfg_wdata  in  8  weight value
- pix_valid  in  1  pixel present
- pix_data  in  8  pixel value
- pix_ready  out  1  controller accepts pixel
- weight_line0  out  24  kernel row 0, weight k at byte k (k = col 0..2)
- weight_line1  out  24  kernel row 1
- weight_line2  out  24  kernel row 2
- data_line0  out  24  window row r-2, byte0 = col c-2, byte2 = col c
- data_line1  out  24  window row r-1
- data_line2  out  24  window row r
- win_vbit  out  1  window valid (to datapath vbit_i)
- res_vbit  in  1  result valid returned from datapath vbit_o
- res_cnt  out  CNT_W  results received this frame
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset: all outputs 0, weights 0, line buffers need not be cleared, state IDLE.
- FSM states: IDLE -> (start) LOAD -> (last pixel accepted, row IMG_H-1 / col IMG_W-1) DRAIN -> (res_cnt reaches N = (IMG_W-2)*(IMG_H-2)) DONE -> IDLE unconditionally after 1 cycle.
- In DONE: done=1. busy=1 in LOAD and DRAIN only.
- On start in IDLE: col, row and res_cnt are cleared. start outside IDLE is ignored.
- Weight writes: a cfg_we with cfg_addr k<=8 is accepted only in IDLE. It writes line k/3, byte k%3. cfg_addr>8 or busy: write ignored.
- pix_ready = (state==LOAD). A pixel is accepted when pix_valid & pix_ready.
- On each accepted pixel: shift into the column shift for the current row. Old rows come from the line buffers at column col. col increments and wraps to 0 at IMG_W-1, and row increments on wrap.
- Window: if the accepted pixel has row>=2 and col>=2, register data_line0..2 and assert win_vbit on the next cycle for exactly 1 cycle.
- data_line0..2 hold their value when there is no window. Latency from accept to win_vbit is 1 cycle.
- pix_valid gaps: stall without losing state. No window is emitted on stall cycles.
- res_vbit: increments res_cnt in LOAD/DRAIN. It is ignored in IDLE/DONE. The count saturates at N.
- If res_cnt reaches N while still in LOAD (not possible with a conforming datapath), the FSM still waits for the last pixel and then exits DRAIN immediately.
- rst mid-frame: return to IDLE at once, weights cleared, no done pulse.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, LOAD, DRAIN, DONE), PIX_W=8, KERNEL=3, and the weight index-to-line/byte mapping constants.
- One sub-module, conv_line_buffer: IMG_W-deep x 8-bit delay line with enable. Two instances chain row r-1 -> row r-2.

Test Plan:
- Weight load: write addr 0..8 with values 0x10..0x18 in IDLE -> weight_line0=24'h121110, weight_line1=24'h151413, weight_line2=24'h181716. Write addr 9 -> no change.
- 4x4 ramp (IMG_W=IMG_H=4), pixels 0x00..0x0F back-to-back:
  - first win_vbit gives data_line0/1/2 = 24'h020100 / 24'h060504 / 24'h0A0908.
  - second gives 24'h030201 / 24'h070605 / 24'h0B0A09.
  - exactly 4 win_vbit pulses in total.
- Same frame with pix_valid toggling every other cycle -> identical 4 windows in order. Each win_vbit is 1 cycle, 1 cycle after its accept.
- Feed 4 res_vbit pulses 2 cycles after each win_vbit -> res_cnt 1..4, done pulses once, busy falls, extra res_vbit ignored.
- start pulsed during LOAD, and cfg_we during LOAD -> no restart, weights unchanged.
- Assert rst after 6 pixels -> all outputs 0, IDLE. A new start then reproduces the 4x4 results from scratch.

Source files
------------

// File: rtl/conv3x3_window_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution window controller.
//   - ctrlState_t : controller FSM encoding (IDLE, LOAD, DRAIN, DONE)
//   - PIX_W, KERNEL, LINE_W : pixel width, kernel size, packed row width
//   - weightLine / weightBit : map a weight index 0..8 to its kernel row
//     and to the bit offset of its byte inside that row
package conv3x3_window_ctrl_pkg;

  localparam int PIX_W   = 8;
  localparam int KERNEL  = 3;
  localparam int W_COUNT = KERNEL * KERNEL;
  localparam int LINE_W  = KERNEL * PIX_W;
  localparam logic [3:0] W_LAST_IDX = 4'(W_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrlState_t;

  // Kernel row holding weight idx (idx / KERNEL).
  function automatic logic [1:0] weightLine(input logic [3:0] idx);
    return 2'(idx / 4'(KERNEL));
  endfunction

  // Bit offset of weight idx inside its row ((idx % KERNEL) bytes).
  function automatic logic [4:0] weightBit(input logic [3:0] idx);
    logic [1:0] col;
    col = 2'(idx % 4'(KERNEL));
    return {col, 3'b000};
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Fixed-length pixel delay line: with en high, din is shifted in and dout
// presents the sample written DEPTH enabled cycles earlier.
//   clk  : clock
//   en   : shift enable (one pixel accepted)
//   din  : pixel in
//   dout : pixel DEPTH accepts ago
module conv_line_buffer
  import conv3x3_window_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] taps [DEPTH];

  // NOTE: storage has no reset; every tap is overwritten before a window
  // ever reads it, so clearing it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Sequencer for the 3x3 convolution datapath.
//   start/busy/done        : frame control (done is a one-cycle pulse)
//   cfg_we/addr/wdata      : weight writes, honoured only while idle
//   pix_valid/ready/data   : raster pixel stream handshake
//   weight_line0..2        : kernel rows, weight col k at byte k
//   data_line0..2, win_vbit: 3x3 window rows r-2..r, byte0 = col c-2
//   res_vbit, res_cnt      : datapath result strobes and their count
module conv3x3_window_ctrl
  import conv3x3_window_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic [23:0]       weight_line0,
  output logic [23:0]       weight_line1,
  output logic [23:0]       weight_line2,
  output logic [23:0]       data_line0,
  output logic [23:0]       data_line1,
  output logic [23:0]       data_line2,
  output logic              win_vbit,
  input  logic              res_vbit,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] RES_TOTAL = CNT_W'((IMG_W - 2) * (IMG_H - 2));

  ctrlState_t state, nextState;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [LINE_W-1:0]   weights [KERNEL];
  logic [PIX_W-1:0]    rowM1Pix, rowM2Pix;
  // Previous two pixels of each window row: col c-1 in the upper byte.
  logic [2*PIX_W-1:0]  shRow0, shRow1, shRow2;
  logic                accept, startFrame, winHit;

  assign accept     = pix_valid && (state == LOAD);
  assign startFrame = start && (state == IDLE);
  assign winHit     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    nextState = state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) nextState = LOAD;
      LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (accept && row == ROW_LAST && col == COL_LAST) nextState = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (res_cnt == RES_TOTAL) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (startFrame) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (startFrame) begin
      res_cnt <= '0;
    end else if ((state == LOAD || state == DRAIN) && res_vbit && res_cnt != RES_TOTAL) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < KERNEL; k++) weights[k] <= '0;
    end else if (cfg_we && state == IDLE && cfg_addr <= W_LAST_IDX) begin
      weights[weightLine(cfg_addr)][weightBit(cfg_addr) +: PIX_W] <= cfg_wdata;
    end
  end

  assign weight_line0 = weights[0];
  assign weight_line1 = weights[1];
  assign weight_line2 = weights[2];

  // Row r-1 is the current pixel delayed one line; row r-2 one more.
  conv_line_buffer #(.DEPTH(IMG_W)) u_lineRowM1 (
    .clk  (clk),
    .en   (accept),
    .din  (pix_data),
    .dout (rowM1Pix)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_lineRowM2 (
    .clk  (clk),
    .en   (accept),
    .din  (rowM1Pix),
    .dout (rowM2Pix)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      shRow2 <= {pix_data, shRow2[2*PIX_W-1:PIX_W]};
      shRow1 <= {rowM1Pix, shRow1[2*PIX_W-1:PIX_W]};
      shRow0 <= {rowM2Pix, shRow0[2*PIX_W-1:PIX_W]};
    end
  end

  // Window rows are captured with the accepted pixel and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vbit   <= 1'b0;
      data_line0 <= '0;
      data_line1 <= '0;
      data_line2 <= '0;
    end else begin
      win_vbit <= winHit;
      if (winHit) begin
        data_line0 <= {rowM2Pix, shRow0};
        data_line1 <= {rowM1Pix, shRow1};
        data_line2 <= {pix_data, shRow2};
      end
    end
  end

endmodule
